// File: rtl/to_afe_az_ctrl_if.sv
// Hit handshake between the TO front-end controller and the pixel-core logic.
// The controller drives valid/tot/fast; the consumer returns ack.
interface to_afe_az_ctrl_if #(
   parameter int unsigned TOT_W = 4
);
   logic             hit_valid;
   logic [TOT_W-1:0] hit_tot;
   logic             hit_fast;
   logic             hit_ack;

   modport master (
      output hit_valid,
      output hit_tot,
      output hit_fast,
      input  hit_ack
   );

   modport slave (
      input  hit_valid,
      input  hit_tot,
      input  hit_fast,
      output hit_ack
   );
endinterface

// File: rtl/to_afe_az_ctrl.sv
// Torino synchronous front-end pixel controller: sequences the discriminator
// autozero phases (S0/S1), owns the AFE power-down, measures ToT on the latch
// output, flags fast hits via the delay line, and presents hits over a
// valid/ack handshake.
module to_afe_az_ctrl #(
   parameter int unsigned PERIOD_W = 12,
   parameter int unsigned TOT_W    = 4,
   parameter int unsigned BLANK    = 2   // must be >= 1
) (
   input  logic                i_clk,
   input  logic                i_reset_b,
   input  logic                i_enable,
   input  logic                i_power_down,
   input  logic [PERIOD_W-1:0] i_az_period,
   input  logic [3:0]          i_az_len,
   input  logic                i_az_req,
   output logic                o_s0,
   output logic                o_s1,
   output logic                o_power_down_to,
   output logic                o_delay_in_to,
   input  logic                i_delay_out_to,
   input  logic                i_voutp_to,
   input  logic                i_voutn_to,
   output logic                o_hit_lost,
   output logic                o_az_busy,
   to_afe_az_ctrl_if.master    io_hit
);

   localparam int unsigned      BlankW    = (BLANK > 1) ? $clog2(BLANK) : 1;
   localparam logic [BlankW-1:0] BlankInit = BlankW'(BLANK - 1);
   localparam logic [TOT_W-1:0]  TotMax    = '1;

   typedef enum logic [2:0] {
      StOff,
      StPre,
      StAz,
      StPost,
      StBlank,
      StIdle
   } state_t;

   state_t              r_state;
   state_t              w_state_d;

   logic                r_s0;
   logic                r_s1;
   logic                r_pd;
   logic                r_busy;
   logic [3:0]          r_az_cnt;
   logic [BlankW-1:0]   r_blank_cnt;
   logic [PERIOD_W-1:0] r_per_cnt;
   logic                r_pending;

   logic                r_disc_q;
   logic                r_active;
   logic                r_fast_pend;
   logic                r_fast;
   logic [TOT_W-1:0]    r_tot;
   logic                r_delay_in;

   logic                r_hit_valid;
   logic [TOT_W-1:0]    r_hit_tot;
   logic                r_hit_fast;
   logic                r_hit_lost;

   logic                w_disc;
   logic                w_force_off;
   logic                w_in_idle;
   logic                w_lead;
   logic                w_trail;
   logic                w_expire;
   logic                w_az_start;
   logic                w_fast;
   logic                w_hit_take;
   logic [3:0]          w_az_len_m1;

   // Equal latch outputs are treated as no hit.
   assign w_disc      = i_voutp_to & ~i_voutn_to;
   assign w_force_off = ~i_enable | i_power_down;
   assign w_in_idle   = (r_state == StIdle);

   assign w_lead  = w_in_idle & w_disc & ~r_disc_q;
   // An abort (force off) swallows a trailing edge so the hit is never reported.
   assign w_trail = w_in_idle & r_active & ~w_disc & ~w_force_off;

   assign w_expire   = w_in_idle & (i_az_period != '0) & (r_per_cnt == PERIOD_W'(1));
   // A leading edge wins over a pending autozero; the request waits for the trailing edge.
   assign w_az_start = (r_pending | w_expire) & ~r_active & ~w_lead;

   // A one-cycle hit ends in the same cycle the delay line is sampled.
   assign w_fast     = r_fast_pend ? i_delay_out_to : r_fast;
   assign w_hit_take = w_trail & (~r_hit_valid | io_hit.hit_ack);

   assign w_az_len_m1 = (i_az_len == 4'd0) ? 4'd0 : (i_az_len - 4'd1);

   // Next-state decode; power down / disable overrides every transition.
   always_comb begin
      w_state_d = r_state;
      case (r_state)
         StOff:   w_state_d = StPre;
         StPre:   w_state_d = StAz;
         StAz:    if (r_az_cnt == 4'd0) w_state_d = StPost;
         StPost:  w_state_d = StBlank;
         StBlank: if (r_blank_cnt == '0) w_state_d = StIdle;
         StIdle:  if (w_az_start) w_state_d = StPre;
         default: w_state_d = StOff;
      endcase
      if (w_force_off) begin
         w_state_d = StOff;
      end
   end

   // State register, phase counters and outputs registered from the next state.
   always_ff @(posedge i_clk or negedge i_reset_b) begin
      if (!i_reset_b) begin
         r_state     <= StOff;
         r_s0        <= 1'b0;
         r_s1        <= 1'b0;
         r_pd        <= 1'b1;
         r_busy      <= 1'b1;
         r_az_cnt    <= 4'd0;
         r_blank_cnt <= '0;
      end else begin
         r_state <= w_state_d;
         r_s0    <= (w_state_d == StAz);
         r_s1    <= (w_state_d == StBlank) || (w_state_d == StIdle);
         r_pd    <= (w_state_d == StOff);
         r_busy  <= (w_state_d != StIdle);
         if (r_state == StPre) begin
            r_az_cnt <= w_az_len_m1;
         end else if ((r_state == StAz) && (r_az_cnt != 4'd0)) begin
            r_az_cnt <= r_az_cnt - 4'd1;
         end
         if (r_state == StPost) begin
            r_blank_cnt <= BlankInit;
         end else if ((r_state == StBlank) && (r_blank_cnt != '0)) begin
            r_blank_cnt <= r_blank_cnt - BlankW'(1);
         end
      end
   end

   // Periodic autozero counter and the pending-request flag.
   always_ff @(posedge i_clk or negedge i_reset_b) begin
      if (!i_reset_b) begin
         r_per_cnt <= '0;
         r_pending <= 1'b0;
      end else begin
         if ((w_state_d == StBlank) && (r_state != StBlank)) begin
            r_per_cnt <= i_az_period;
         end else if (w_in_idle && (i_az_period != '0) && (r_per_cnt != '0)) begin
            r_per_cnt <= r_per_cnt - PERIOD_W'(1);
         end
         if ((w_state_d == StOff) || ((w_state_d == StPost) && (r_state != StPost))) begin
            r_pending <= 1'b0;
         end else if ((i_az_req && (r_state != StOff)) || w_expire) begin
            r_pending <= 1'b1;
         end
      end
   end

   // ToT measurement, fast-flag capture and delay line drive.
   always_ff @(posedge i_clk or negedge i_reset_b) begin
      if (!i_reset_b) begin
         r_disc_q    <= 1'b0;
         r_active    <= 1'b0;
         r_fast_pend <= 1'b0;
         r_fast      <= 1'b0;
         r_tot       <= '0;
         r_delay_in  <= 1'b0;
      end else begin
         r_disc_q    <= w_disc;
         r_delay_in  <= w_disc & w_in_idle & (w_state_d == StIdle);
         r_fast_pend <= w_lead & (w_state_d == StIdle);
         if (w_state_d != StIdle) begin
            r_active <= 1'b0;
         end else if (w_lead) begin
            r_active <= 1'b1;
         end else if (w_trail) begin
            r_active <= 1'b0;
         end
         if (w_lead) begin
            r_tot <= TOT_W'(1);
         end else if (r_active && w_disc && (r_tot != TotMax)) begin
            r_tot <= r_tot + TOT_W'(1);
         end
         if (r_fast_pend) begin
            r_fast <= i_delay_out_to;
         end
      end
   end

   // Hit output register: accept on trailing edge if free or being acked, else drop.
   always_ff @(posedge i_clk or negedge i_reset_b) begin
      if (!i_reset_b) begin
         r_hit_valid <= 1'b0;
         r_hit_tot   <= '0;
         r_hit_fast  <= 1'b0;
         r_hit_lost  <= 1'b0;
      end else begin
         if (w_hit_take) begin
            r_hit_valid <= 1'b1;
            r_hit_tot   <= r_tot;
            r_hit_fast  <= w_fast;
         end else begin
            if (w_trail) begin
               r_hit_lost <= 1'b1;
            end
            if (r_hit_valid && io_hit.hit_ack) begin
               r_hit_valid <= 1'b0;
            end
         end
      end
   end

   assign o_s0            = r_s0;
   assign o_s1            = r_s1;
   assign o_power_down_to = r_pd;
   assign o_delay_in_to   = r_delay_in;
   assign o_hit_lost      = r_hit_lost;
   assign o_az_busy       = r_busy;
   assign io_hit.hit_valid = r_hit_valid;
   assign io_hit.hit_tot   = r_hit_tot;
   assign io_hit.hit_fast  = r_hit_fast;

endmodule

// File: tb/tb_to_afe_az_ctrl.sv
// Self-checking bench for to_afe_az_ctrl: autozero sequencing, ToT/fast hits
// through a scoreboard, handshake loss/replace, periodic autozero, power down.
module tb_to_afe_az_ctrl;

   typedef struct packed {
      logic [3:0] tot;
      logic       fast;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        power_down;
   logic [11:0] az_period;
   logic [3:0]  az_len;
   logic        az_req;
   logic        s0;
   logic        s1;
   logic        pd_to;
   logic        delay_in;
   logic        delay_out;
   logic        vp;
   logic        vn;
   logic        hit_lost;
   logic        az_busy;

   int          n_checks = 0;
   int          n_fail   = 0;
   exp_t        sb_q[$];

   to_afe_az_ctrl_if #(.TOT_W(4)) hit_if ();

   to_afe_az_ctrl #(
      .PERIOD_W (12),
      .TOT_W    (4),
      .BLANK    (2)
   ) u_dut (
      .i_clk           (clk),
      .i_reset_b       (rst_n),
      .i_enable        (enable),
      .i_power_down    (power_down),
      .i_az_period     (az_period),
      .i_az_len        (az_len),
      .i_az_req        (az_req),
      .o_s0            (s0),
      .o_s1            (s1),
      .o_power_down_to (pd_to),
      .o_delay_in_to   (delay_in),
      .i_delay_out_to  (delay_out),
      .i_voutp_to      (vp),
      .i_voutn_to      (vn),
      .o_hit_lost      (hit_lost),
      .o_az_busy       (az_busy),
      .io_hit          (hit_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d required %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard consumer: every transfer pops the oldest expected hit.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && hit_if.hit_valid && hit_if.hit_ack) begin
         if (sb_q.size() == 0) begin
            check_eq("sb_underflow", sb_q.size(), 1);
         end else begin
            e = sb_q.pop_front();
            check_eq("sb_tot", hit_if.hit_tot, e.tot);
            check_eq("sb_fast", hit_if.hit_fast, e.fast);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ack_pulse();
      hit_if.hit_ack = 1'b1;
      tick(1);
      hit_if.hit_ack = 1'b0;
   endtask

   task automatic wait_pre(input string tag);
      int n;
      n = 0;
      while (!(az_busy && !pd_to && !s0 && !s1) && n < 40) begin
         tick(1);
         n++;
      end
      check_eq(tag, (n < 40) ? 1 : 0, 1);
   endtask

   // Called on the PRE cycle; returns on the first IDLE cycle.
   task automatic az_seq(input int len, input bit poke);
      check_eq("pre_s0", s0, 0);
      check_eq("pre_s1", s1, 0);
      check_eq("pre_busy", az_busy, 1);
      for (int i = 0; i < len; i++) begin
         tick(1);
         check_eq("az_s0", s0, 1);
         check_eq("az_s1", s1, 0);
      end
      tick(1);
      check_eq("post_s0", s0, 0);
      check_eq("post_s1", s1, 0);
      for (int i = 0; i < 2; i++) begin
         tick(1);
         check_eq("blank_s1", s1, 1);
         check_eq("blank_s0", s0, 0);
         check_eq("blank_busy", az_busy, 1);
         if (poke) vp = 1'b1;
      end
      tick(1);
      check_eq("idle_s1", s1, 1);
      check_eq("idle_busy", az_busy, 0);
      check_eq("idle_pd", pd_to, 0);
      if (poke) vp = 1'b0;
   endtask

   // Drive one hit of len cycles; returns on the cycle after the trailing edge.
   task automatic hit(input int len, input bit dly, input bit keep, input bit trail_ack);
      exp_t e;
      e.tot  = (len > 15) ? 4'd15 : 4'(len);
      e.fast = dly;
      if (keep) sb_q.push_back(e);
      vp = 1'b1;
      vn = 1'b0;
      tick(1);
      check_eq("delay_in", delay_in, 1);
      delay_out = dly;
      if (len == 1) begin
         vp = 1'b0;
         if (trail_ack) hit_if.hit_ack = 1'b1;
      end
      tick(1);
      delay_out = 1'b0;
      if (len > 1) begin
         repeat (len - 2) tick(1);
         vp = 1'b0;
         if (trail_ack) hit_if.hit_ack = 1'b1;
         tick(1);
      end
      if (trail_ack) hit_if.hit_ack = 1'b0;
   endtask

   initial begin : main
      int n;
      rst_n = 1'b0;
      enable = 1'b0;
      power_down = 1'b0;
      az_period = 12'd0;
      az_len = 4'd3;
      az_req = 1'b0;
      delay_out = 1'b0;
      vp = 1'b0;
      vn = 1'b0;
      hit_if.hit_ack = 1'b0;
      tick(3);
      check_eq("rst_s0", s0, 0);
      check_eq("rst_s1", s1, 0);
      check_eq("rst_pd", pd_to, 1);
      check_eq("rst_delay_in", delay_in, 0);
      check_eq("rst_valid", hit_if.hit_valid, 0);
      check_eq("rst_tot", hit_if.hit_tot, 0);
      check_eq("rst_fast", hit_if.hit_fast, 0);
      check_eq("rst_lost", hit_lost, 0);
      check_eq("rst_busy", az_busy, 1);

      // Startup autozero, with disc poked during blanking.
      enable = 1'b1;
      rst_n = 1'b1;
      wait_pre("wait_startup");
      az_seq(3, 1'b1);
      tick(3);
      check_eq("blank_ignored", hit_if.hit_valid, 0);

      // Basic hits: nominal, saturated, single cycle.
      hit(5, 1'b0, 1'b1, 1'b0);
      check_eq("hit5_valid", hit_if.hit_valid, 1);
      check_eq("hit5_tot", hit_if.hit_tot, 5);
      ack_pulse();
      check_eq("ack_clears", hit_if.hit_valid, 0);
      tick(2);
      hit(20, 1'b1, 1'b1, 1'b0);
      check_eq("sat_tot", hit_if.hit_tot, 15);
      check_eq("sat_fast", hit_if.hit_fast, 1);
      ack_pulse();
      tick(2);
      hit(1, 1'b1, 1'b1, 1'b0);
      check_eq("one_valid", hit_if.hit_valid, 1);
      check_eq("one_tot", hit_if.hit_tot, 1);
      ack_pulse();
      tick(2);

      // Hit completing in the ack cycle replaces the old one without loss.
      hit(4, 1'b0, 1'b1, 1'b0);
      tick(2);
      hit(7, 1'b1, 1'b1, 1'b1);
      check_eq("repl_valid", hit_if.hit_valid, 1);
      check_eq("repl_tot", hit_if.hit_tot, 7);
      check_eq("repl_lost", hit_lost, 0);
      ack_pulse();
      tick(2);

      // Equal latch outputs are not a hit.
      vp = 1'b1;
      vn = 1'b1;
      tick(5);
      check_eq("eq_delay_in", delay_in, 0);
      vp = 1'b0;
      vn = 1'b0;
      tick(3);
      check_eq("eq_no_hit", hit_if.hit_valid, 0);

      // Periodic autozero.
      az_period = 12'd10;
      az_req = 1'b1;
      tick(1);
      az_req = 1'b0;
      wait_pre("wait_req");
      az_seq(3, 1'b0);
      n = 0;
      while (!az_busy && n < 40) begin
         n++;
         tick(1);
      end
      check_eq("period_idle_cycles", n, 10);
      az_seq(3, 1'b0);
      tick(4);
      hit_if.hit_ack = 1'b1;
      hit(12, 1'b0, 1'b1, 1'b0);
      check_eq("defer_busy", az_busy, 0);
      check_eq("defer_valid", hit_if.hit_valid, 1);
      tick(1);
      hit_if.hit_ack = 1'b0;
      check_eq("defer_pre", az_busy, 1);
      az_period = 12'd0;
      az_seq(3, 1'b0);
      n = 0;
      repeat (40) begin
         tick(1);
         if (az_busy) n++;
      end
      check_eq("no_periodic", n, 0);

      // Power down in the middle of autozero.
      az_req = 1'b1;
      tick(1);
      az_req = 1'b0;
      wait_pre("wait_req2");
      tick(2);
      check_eq("midaz_s0", s0, 1);
      power_down = 1'b1;
      tick(1);
      check_eq("pdaz_s0", s0, 0);
      check_eq("pdaz_s1", s1, 0);
      check_eq("pdaz_pd", pd_to, 1);
      check_eq("pdaz_busy", az_busy, 1);
      tick(2);
      power_down = 1'b0;
      wait_pre("wait_pd_az");
      az_seq(3, 1'b0);

      // Power down in the middle of a ToT count: hit is aborted.
      vp = 1'b1;
      tick(3);
      power_down = 1'b1;
      tick(1);
      check_eq("pdtot_pd", pd_to, 1);
      check_eq("pdtot_s1", s1, 0);
      check_eq("pdtot_valid", hit_if.hit_valid, 0);
      vp = 1'b0;
      tick(2);
      check_eq("pdtot_valid2", hit_if.hit_valid, 0);
      power_down = 1'b0;
      wait_pre("wait_pd_tot");
      az_seq(3, 1'b0);
      tick(2);
      check_eq("abort_no_hit", hit_if.hit_valid, 0);

      // Second hit while the first is unacked is lost.
      hit(3, 1'b0, 1'b1, 1'b0);
      tick(2);
      hit(6, 1'b1, 1'b0, 1'b0);
      check_eq("lost_flag", hit_lost, 1);
      check_eq("lost_valid", hit_if.hit_valid, 1);
      check_eq("lost_tot_kept", hit_if.hit_tot, 3);
      ack_pulse();
      check_eq("lost_sticky", hit_lost, 1);
      check_eq("lost_drained", hit_if.hit_valid, 0);
      tick(2);

      // Asynchronous reset mid-handshake.
      hit(2, 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_valid", hit_if.hit_valid, 0);
      check_eq("arst_lost", hit_lost, 0);
      check_eq("arst_tot", hit_if.hit_tot, 0);
      check_eq("arst_pd", pd_to, 1);
      check_eq("arst_s1", s1, 0);
      check_eq("arst_busy", az_busy, 1);
      tick(2);
      check_eq("sb_empty", sb_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/to_afe_az_ctrl.md
Name: to_afe_az_ctrl

Overview:
- Pixel-level digital controller for the Torino synchronous front end, acting on the fe_control side of the TO digital interface.
- Sequences the discriminator autozero phases (S0/S1) periodically or on request.
- Owns POWER_DOWN_TO and samples the differential latch output (VOUTP_TO/VOUTN_TO) into a ToT measurement.
- Adds a fast-mode leading-edge flag using the delay line, and presents each completed hit to the pixel-core logic with a valid/ack handshake.

Parameters:
PERIOD_W, 12, width of autozero period counter (in CLK cycles)
TOT_W, 4, width of ToT result; counter saturates at 2^TOT_W-1
BLANK, 2, cycles of hit blanking after S1 re-asserts

Ports:
CLK  in  1  40 MHz bunch-crossing clock
RESET_B  in  1  asynchronous active-low reset
ENABLE  in  1  pixel enable (config)
POWER_DOWN  in  1  front-end power down request (config)
AZ_PERIOD  in  PERIOD_W  periodic autozero interval; 0 = periodic disabled
AZ_LEN  in  4  S0 high duration in cycles; 0 treated as 1
AZ_REQ  in  1  single-cycle external autozero request
S0  out  1  autozero phase 0 to AFE
S1  out  1  autozero phase 1 to AFE (compare phase)
POWER_DOWN_TO  out  1  AFE power down
DELAY_IN_TO  out  1  delay line input (fast mode)
DELAY_OUT_TO  in  1  delay line output
VOUTP_TO  in  1  latch output, positive
VOUTN_TO  in  1  latch output, negative
HIT_VALID  out  1  completed hit available
HIT_TOT  out  TOT_W  ToT of presented hit
HIT_FAST  out  1  DELAY_OUT_TO was high one cycle after leading edge
HIT_ACK  in  1  consumer accepts hit (valid & ack = transfer)
HIT_LOST  out  1  sticky: a hit was dropped; cleared by RESET_B only
AZ_BUSY  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - S0=0, S1=0, POWER_DOWN_TO=1, DELAY_IN_TO=0.
  - HIT_VALID=0, HIT_TOT=0, HIT_FAST=0, HIT_LOST=0, AZ_BUSY=1.
  - State OFF; all counters 0; az_pending=0.
- Discriminator: disc = VOUTP_TO & ~VOUTN_TO, sampled each CLK. Equal VOUTP/VOUTN counts as no hit.
- FSM states and transitions:
  - OFF: S0=S1=0, PD=1. Leaves to PRE when ENABLE & ~POWER_DOWN. Startup always autozeroes.
  - PRE: S0=S1=0 for 1 cycle (non-overlap), then AZ.
  - AZ: S0=1 for max(AZ_LEN,1) cycles, then POST.
  - POST: S0=S1=0 for 1 cycle, then BLANKING. az_pending is cleared on entry to POST.
  - BLANKING: S1=1, disc ignored for BLANK cycles, then IDLE. The period counter reloads to AZ_PERIOD on entry.
  - IDLE: S1=1, hits accepted. Goes to PRE when (az_pending or period counter expires) and no ToT count is active.
  - Any state: ~ENABLE or POWER_DOWN forces OFF the next cycle and aborts any hit in progress (not reported).
- S0 and S1 are never both 1. Every S1 1->0 or 0->1 transition is separated from S0 high by at least one cycle.
- Period counter: decrements in IDLE when AZ_PERIOD≠0. Reaching 0 sets az_pending. A pending request while a ToT count is active is deferred until the trailing edge.
- AZ_REQ: sets az_pending in any state except OFF. It is ignored in OFF. A second AZ_REQ while pending has no further effect.
- ToT measurement (IDLE only):
  - Leading edge: disc 0->1.
  - tot starts at 1 on the leading-edge cycle and increments each cycle disc stays 1, saturating at 2^TOT_W-1.
  - Trailing edge: disc 1->0 ends the count.
- DELAY_IN_TO: registered disc while in IDLE, 0 otherwise. fast_bit captures DELAY_OUT_TO in the cycle after the leading edge.
- Output register: on the trailing edge, if HIT_VALID=0 or (HIT_VALID & HIT_ACK) in the same cycle, the next cycle has HIT_VALID=1 with HIT_TOT=tot and HIT_FAST=fast_bit. Otherwise the new hit is dropped and HIT_LOST is set.
- HIT_VALID & HIT_ACK without a new hit clears HIT_VALID the next cycle. HIT_TOT and HIT_FAST hold their values until replaced. HIT_ACK while HIT_VALID=0 is ignored.
- Latency: HIT_VALID rises 1 cycle after the first cycle with disc=0.
- Reset mid-operation: asynchronous return to reset values, regardless of state or handshake.

Test Plan:
- Reset release, ENABLE=1, POWER_DOWN=0, AZ_LEN=3 -> S0/S1: 1 cycle 00, 3 cycles S0=1, 1 cycle 00, then S1=1; hits ignored for 2 cycles; AZ_BUSY falls on entry to IDLE.
- In IDLE, VOUTP=1/VOUTN=0 for 5 cycles -> HIT_VALID=1 with HIT_TOT=5 one cycle after the trailing edge; disc held 20 cycles -> HIT_TOT=15 (saturated).
- HIT_ACK held 0, two separate hits -> first retained (TOT unchanged), HIT_LOST=1; hit completing in the same cycle as ACK -> replaces the old hit with no loss.
- AZ_PERIOD=10 with a hit spanning counter expiry -> PRE entered only after the trailing edge; next autozero occurs 10 IDLE cycles after BLANKING ends; AZ_PERIOD=0 -> no autozero without AZ_REQ.
- POWER_DOWN=1 mid-AZ and mid-ToT -> next cycle OFF, S0=S1=0, POWER_DOWN_TO=1, no HIT_VALID; deassert -> full autozero sequence repeats.
- DELAY_OUT_TO=1 in the cycle after the leading edge -> HIT_FAST=1; DELAY_OUT_TO=0 -> HIT_FAST=0; VOUTP=VOUTN=1 -> no hit.
